bool_eval_sequencer: RTL
========================

// Module: bool_eval_sequencer
// PURPOSE
//  Self-test sequencer for the 3-input boolean stage e = (~a&~b)|~c.
//  On start, walks {a,b,c} through all 8 vectors (000..111), waits SETTLE_CYCLES per vector,
//  samples e, builds a captured truth table and compares it against EXP_TABLE.
//  Sits between board controls (button/switch) and the boolean datapath; reports pass/fail to LEDs.
// PARAMETERS
//  SETTLE_CYCLES  2      clocks each vector is held before e is sampled (legal range 1..255)
//  EXP_TABLE      8'h57  expected e per vector; bit i = e for {a,b,c}=i (8'h57 = (~a&~b)|~c)
// PORTS
//  clk        in   1  single system clock; all state updates on the rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  start      in   1  level; sampled only in IDLE; launches a sweep
//  abort      in   1  level; ends the sweep from any non-IDLE state
//  e_i        in   1  output of the boolean stage (combinational from a_o,b_o,c_o)
//  a_o        out  1  vector bit 2 to the datapath
//  b_o        out  1  vector bit 1
//  c_o        out  1  vector bit 0
//  busy       out  1  high while a sweep is in progress
//  done       out  1  one-cycle pulse when a sweep completes
//  pass       out  1  captured == EXP_TABLE; valid from done, held until next start/abort
//  captured   out  8  sampled e per vector (bit i = vector i)
//  fail_mask  out  8  captured ^ EXP_TABLE; valid with pass
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; a_o,b_o,c_o,busy,done,pass=0; captured,fail_mask=8'h00;
//   vector index=0, settle counter=0. Takes effect immediately, including mid-sweep.
//  FSM states: IDLE, SETTLE, DONE.
//   IDLE: outputs a/b/c=0, busy=0. start=1 at an edge -> SETTLE, idx=0, cnt=SETTLE_CYCLES-1,
//    captured/fail_mask/pass cleared to 0.
//   SETTLE: busy=1, {a_o,b_o,c_o}=idx (registered). Each edge with cnt!=0: cnt--.
//    At an edge with cnt==0: captured[idx]<=e_i; if idx==7 -> DONE, else idx++ and
//    cnt reloads SETTLE_CYCLES-1.
//   DONE (one cycle): done=1, busy=0, a/b/c=0; pass and fail_mask registered from the final
//    captured value (including the bit written at the last edge of SETTLE). Next edge -> IDLE.
//  Timing: start seen at edge 0 -> busy high for exactly 8*SETTLE_CYCLES cycles starting after
//   edge 0; done high in the following cycle; idle again after that.
//  start is ignored outside IDLE (no restart, no queuing). Held start re-launches a new sweep on
//   the edge after DONE returns to IDLE.
//  abort (SETTLE or DONE): next state IDLE; no done pulse; captured, fail_mask, pass cleared to 0;
//   a/b/c=0. abort has priority over start and over the DONE transition.
//  Simultaneous start+abort in IDLE: abort wins, stay IDLE.
//  idx is 3 bits; never wraps within a sweep (7 terminates). cnt width = clog2(SETTLE_CYCLES)+1.
//  Bits of captured not yet sampled read 0 while busy.
// TESTING
//  T1 S=2, correct DUT model, start pulse: a/b/c step 000..111 every 2 clks; done at cycle 17;
//     captured=8'h57, fail_mask=8'h00, pass=1.
//  T2 S=2, e_i stuck at 0: captured=8'h00, fail_mask=8'h57, pass=0; done timing as T1.
//  T3 S=1, correct DUT: busy for 8 cycles, done at cycle 9, pass=1; vector changes every clk.
//  T4 abort asserted while idx=3: busy=0 next cycle, no done pulse, captured=0, pass=0, a/b/c=0.
//  T5 start re-pulsed at idx=2 and idx=5: ignored; sweep completes on original schedule, pass=1.
//  T6 rst_n low mid-sweep (idx=4) between edges: all outputs 0 at once; after release, start
//     gives a full fresh sweep with pass=1.

Source files
------------

// File: rtl/bool_eval_if.sv
// Handshake and result bundle between the board-side controller and the boolean self-test sequencer.
interface bool_eval_if;
    logic       start;
    logic       abort;
    logic       e_i;
    logic       a_o;
    logic       b_o;
    logic       c_o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured;
    logic [7:0] fail_mask;

    modport slave (
        input  start, abort, e_i,
        output a_o, b_o, c_o, busy, done, pass, captured, fail_mask
    );

    modport master (
        output start, abort, e_i,
        input  a_o, b_o, c_o, busy, done, pass, captured, fail_mask
    );
endinterface

// File: rtl/bool_eval_sequencer.sv
// Walks {a,b,c} through all eight vectors, samples the boolean stage after a settle delay,
// and compares the captured truth table against the expected one.
//
// state  | meaning
// IDLE   | waiting for start; vector outputs parked at 000
// SETTLE | driving vector idx, counting down cnt, sampling e_i at terminal count
// DONE   | one-cycle done pulse; pass/fail_mask hold the verdict
module bool_eval_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXP_TABLE     = 8'h57
) (
    input  logic         clk,
    input  logic         rst_n,
    bool_eval_if.slave   bus
);

    localparam int            CW       = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    captured, captured_nxt;
    logic [7:0]    fail_mask, fail_mask_nxt;
    logic          pass, pass_nxt;
    logic [7:0]    cap_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= '0;
            captured  <= 8'h00;
            fail_mask <= 8'h00;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            captured  <= captured_nxt;
            fail_mask <= fail_mask_nxt;
            pass      <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        captured_nxt  = captured;
        fail_mask_nxt = fail_mask;
        pass_nxt      = pass;
        // Table including the bit sampled on this edge, so the verdict sees all eight vectors.
        cap_sample      = captured;
        cap_sample[idx] = bus.e_i;

        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt     = SETTLE;
                    idx_nxt       = 3'd0;
                    cnt_nxt       = CNT_LOAD;
                    captured_nxt  = 8'h00;
                    fail_mask_nxt = 8'h00;
                    pass_nxt      = 1'b0;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_nxt     = IDLE;
                    idx_nxt       = 3'd0;
                    cnt_nxt       = '0;
                    captured_nxt  = 8'h00;
                    fail_mask_nxt = 8'h00;
                    pass_nxt      = 1'b0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    captured_nxt = cap_sample;
                    if (idx == 3'd7) begin
                        state_nxt     = DONE;
                        fail_mask_nxt = cap_sample ^ EXP_TABLE;
                        pass_nxt      = (cap_sample == EXP_TABLE);
                    end else begin
                        idx_nxt = idx + 3'd1;
                        cnt_nxt = CNT_LOAD;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
                cnt_nxt   = '0;
                if (bus.abort) begin
                    captured_nxt  = 8'h00;
                    fail_mask_nxt = 8'h00;
                    pass_nxt      = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign {bus.a_o, bus.b_o, bus.c_o} = (state == SETTLE) ? idx : 3'b000;
    assign bus.busy      = (state == SETTLE);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass;
    assign bus.captured  = captured;
    assign bus.fail_mask = fail_mask;

endmodule
